// File: rtl/elevator_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler_if
// Description : Request/IO-latch side bundle of the elevator scheduler: latched
//               floor requests and door-button levels in, clear pulses and
//               car/motor/door status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface elevator_scheduler_if #(
  parameter int FLOORS = 8
);
  logic [FLOORS-1:0]         floor_req;
  logic                      open_door_sig;
  logic                      close_door_sig;
  logic [FLOORS-1:0]         flag_req;
  logic                      flag_open_door_sig;
  logic                      flag_close_door_sig;
  logic [$clog2(FLOORS)-1:0] cur_floor;
  logic                      dir_up;
  logic                      motor_up;
  logic                      motor_down;
  logic                      door_open;

  // Latch block side: presents requests, consumes the clear pulses.
  modport master (
    output floor_req, open_door_sig, close_door_sig,
    input  flag_req, flag_open_door_sig, flag_close_door_sig,
    input  cur_floor, dir_up, motor_up, motor_down, door_open
  );

  // Scheduler side.
  modport slave (
    input  floor_req, open_door_sig, close_door_sig,
    output flag_req, flag_open_door_sig, flag_close_door_sig,
    output cur_floor, dir_up, motor_up, motor_down, door_open
  );
endinterface
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler
// Description : SCAN sequencing controller for one elevator car. Times travel
//               and door dwell, drives motor/door, and returns one-cycle clear
//               pulses for served requests and acknowledged door buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_scheduler #(
  parameter int FLOORS      = 8,
  parameter int MOVE_CYCLES = 16,
  parameter int DOOR_CYCLES = 32
) (
  input  logic                clk,
  input  logic                reset,
  elevator_scheduler_if.slave bus
);
  localparam int FW   = $clog2(FLOORS);
  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_MOVING    = 2'd1;
  localparam logic [1:0] S_ARRIVE    = 2'd2;
  localparam logic [1:0] S_DOOR_OPEN = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [FW-1:0]     floor, floor_nxt;
  logic              dir, dir_nxt;
  logic [FLOORS-1:0] req_pulse, req_pulse_nxt;
  logic              open_pulse, open_pulse_nxt;
  logic              close_pulse, close_pulse_nxt;
  logic              mot_up, mot_dn, door;

  logic              above, below;
  logic              here_eff, open_eff, close_eff;
  logic              go_up, ahead;
  logic [FLOORS-1:0] onehot;

  // Requests strictly above / below the car position.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(floor)) above = above | bus.floor_req[i];
      if (i < int'(floor)) below = below | bus.floor_req[i];
    end
  end

  // An input whose ack is on the wire this cycle is still the old latched
  // level; masking it keeps one sampled level from being acked twice.
  assign here_eff  = bus.floor_req[floor] & ~req_pulse[floor];
  assign open_eff  = bus.open_door_sig & ~open_pulse;
  assign close_eff = bus.close_door_sig & ~close_pulse;
  assign go_up     = above & (dir | ~below);
  assign ahead     = dir ? above : below;
  assign onehot    = FLOORS'(1) << floor;

  // Next-state, timer, position and pulse decisions.
  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    floor_nxt       = floor;
    dir_nxt         = dir;
    req_pulse_nxt   = '0;
    open_pulse_nxt  = 1'b0;
    close_pulse_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        close_pulse_nxt = close_eff;
        if (here_eff || open_eff) begin
          state_nxt      = S_DOOR_OPEN;
          timer_nxt      = DOOR_LOAD;
          req_pulse_nxt  = here_eff ? onehot : '0;
          open_pulse_nxt = open_eff;
        end else if (go_up) begin
          dir_nxt   = 1'b1;
          state_nxt = S_MOVING;
          timer_nxt = MOVE_LOAD;
        end else if (below) begin
          dir_nxt   = 1'b0;
          state_nxt = S_MOVING;
          timer_nxt = MOVE_LOAD;
        end
      end
      S_MOVING: begin
        open_pulse_nxt  = open_eff;
        close_pulse_nxt = close_eff;
        if (timer == '0) begin
          state_nxt = S_ARRIVE;
          if (dir) begin
            if (floor != TOP_FLOOR) floor_nxt = floor + 1'b1;
          end else begin
            if (floor != '0) floor_nxt = floor - 1'b1;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_ARRIVE: begin
        open_pulse_nxt  = open_eff;
        close_pulse_nxt = close_eff;
        if (here_eff) begin
          state_nxt     = S_DOOR_OPEN;
          timer_nxt     = DOOR_LOAD;
          req_pulse_nxt = onehot;
        end else if (ahead) begin
          state_nxt = S_MOVING;
          timer_nxt = MOVE_LOAD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DOOR_OPEN: begin
        // open beats a new call here, which beats close, which beats timeout
        if (open_eff) begin
          timer_nxt      = DOOR_LOAD;
          open_pulse_nxt = 1'b1;
        end else if (here_eff) begin
          timer_nxt     = DOOR_LOAD;
          req_pulse_nxt = onehot;
        end else if (close_eff) begin
          close_pulse_nxt = 1'b1;
          state_nxt       = S_IDLE;
        end else if (timer == '0) begin
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; motor/door outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      floor       <= '0;
      dir         <= 1'b1;
      req_pulse   <= '0;
      open_pulse  <= 1'b0;
      close_pulse <= 1'b0;
      mot_up      <= 1'b0;
      mot_dn      <= 1'b0;
      door        <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      floor       <= floor_nxt;
      dir         <= dir_nxt;
      req_pulse   <= req_pulse_nxt;
      open_pulse  <= open_pulse_nxt;
      close_pulse <= close_pulse_nxt;
      mot_up      <= (state_nxt == S_MOVING) && dir_nxt;
      mot_dn      <= (state_nxt == S_MOVING) && !dir_nxt;
      door        <= (state_nxt == S_DOOR_OPEN);
    end
  end

  assign bus.flag_req            = req_pulse;
  assign bus.flag_open_door_sig  = open_pulse;
  assign bus.flag_close_door_sig = close_pulse;
  assign bus.cur_floor           = floor;
  assign bus.dir_up              = dir;
  assign bus.motor_up            = mot_up;
  assign bus.motor_down          = mot_dn;
  assign bus.door_open           = door;
endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_scheduler
// Description : Self-checking bench for elevator_scheduler (8 floors,
//               MOVE_CYCLES=4, DOOR_CYCLES=8) with a behavioural IO latch that
//               drops inputs one cycle after their clear pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elevator_scheduler_if #(.FLOORS(8)) bus ();

  elevator_scheduler #(.FLOORS(8), .MOVE_CYCLES(4), .DOOR_CYCLES(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] fr;
    logic       fo, fc;
    logic [2:0] fl;
    logic       dir, mu, md, door;
  } exp_t;

  typedef struct {
    logic [7:0] req;
    logic       op, cl;
    logic [7:0] fr;
    logic       fo, fc;
    logic [2:0] fl;
    logic       dir, mu, md, door;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[14];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] req_l   = 8'h00;
  logic [7:0] pend_fr = 8'h00;
  logic       open_l  = 1'b0, close_l = 1'b0;
  logic       pend_fo = 1'b0, pend_fc = 1'b0;

  function automatic vec_t mk(input logic [7:0] req, input logic op, input logic cl,
                              input logic [7:0] fr, input logic fo, input logic fc,
                              input logic [2:0] fl, input logic d, input logic mu,
                              input logic md, input logic dr);
    vec_t v;
    v.req = req; v.op = op; v.cl = cl; v.fr = fr; v.fo = fo; v.fc = fc;
    v.fl = fl; v.dir = d; v.mu = mu; v.md = md; v.door = dr;
    return v;
  endfunction

  task automatic drive();
    bus.floor_req      = req_l;
    bus.open_door_sig  = open_l;
    bus.close_door_sig = close_l;
  endtask

  task automatic expect_at(input int c, input string nm, input logic [7:0] fr,
                           input logic fo, input logic fc, input logic [2:0] fl,
                           input logic d, input logic mu, input logic md, input logic dr);
    exp_t e;
    e.cyc = c; e.name = nm; e.fr = fr; e.fo = fo; e.fc = fc;
    e.fl = fl; e.dir = d; e.mu = mu; e.md = md; e.door = dr;
    sbq.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [16:0] got, want;
    got  = {bus.flag_req, bus.flag_open_door_sig, bus.flag_close_door_sig, bus.cur_floor,
            bus.dir_up, bus.motor_up, bus.motor_down, bus.door_open};
    want = {e.fr, e.fo, e.fc, e.fl, e.dir, e.mu, e.md, e.door};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got fr=%h fo=%b fc=%b fl=%0d dir=%b mu=%b md=%b door=%b want fr=%h fo=%b fc=%b fl=%0d dir=%b mu=%b md=%b door=%b",
               e.name, cyc, bus.flag_req, bus.flag_open_door_sig, bus.flag_close_door_sig,
               bus.cur_floor, bus.dir_up, bus.motor_up, bus.motor_down, bus.door_open,
               e.fr, e.fo, e.fc, e.fl, e.dir, e.mu, e.md, e.door);
    end
  endtask

  // One clock: latch model drops inputs acked last cycle, then due entries are checked.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    req_l = req_l & ~pend_fr;
    if (pend_fo) open_l = 1'b0;
    if (pend_fc) close_l = 1'b0;
    pend_fr = bus.flag_req;
    pend_fo = bus.flag_open_door_sig;
    pend_fc = bus.flag_close_door_sig;
    drive();
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      compare(e);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int base;
    reset = 1'b1;
    drive();

    // single-floor trip 0 -> 1 with full door dwell
    tbl[0]  = mk(8'h02, 0, 0, 8'h00, 0, 0, 3'd0, 1, 1, 0, 0);
    tbl[1]  = mk(8'h00, 0, 0, 8'h00, 0, 0, 3'd0, 1, 1, 0, 0);
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = mk(8'h00, 0, 0, 8'h00, 0, 0, 3'd1, 1, 0, 0, 0);
    tbl[5]  = mk(8'h00, 0, 0, 8'h02, 0, 0, 3'd1, 1, 0, 0, 1);
    for (int i = 6; i <= 12; i++) tbl[i] = mk(8'h00, 0, 0, 8'h00, 0, 0, 3'd1, 1, 0, 0, 1);
    tbl[13] = mk(8'h00, 0, 0, 8'h00, 0, 0, 3'd1, 1, 0, 0, 0);

    expect_at(2, "reset_state", 8'h00, 0, 0, 3'd0, 1, 0, 0, 0);
    run(2);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      req_l = req_l | tbl[i].req;
      if (tbl[i].op) open_l = 1'b1;
      if (tbl[i].cl) close_l = 1'b1;
      drive();
      expect_at(cyc + 1, $sformatf("trip01_row%0d", i), tbl[i].fr, tbl[i].fo, tbl[i].fc,
                tbl[i].fl, tbl[i].dir, tbl[i].mu, tbl[i].md, tbl[i].door);
      step();
    end

    // floor 1 -> 3, close button pressed mid-travel
    base = cyc;
    req_l = req_l | 8'h08;
    drive();
    expect_at(base + 1,  "mv_up_start",   8'h00, 0, 0, 3'd1, 1, 1, 0, 0);
    expect_at(base + 3,  "close_mv_ack",  8'h00, 0, 1, 3'd1, 1, 1, 0, 0);
    expect_at(base + 4,  "close_mv_once", 8'h00, 0, 0, 3'd1, 1, 1, 0, 0);
    expect_at(base + 5,  "arrive_f2",     8'h00, 0, 0, 3'd2, 1, 0, 0, 0);
    expect_at(base + 6,  "pass_f2",       8'h00, 0, 0, 3'd2, 1, 1, 0, 0);
    expect_at(base + 10, "arrive_f3",     8'h00, 0, 0, 3'd3, 1, 0, 0, 0);
    expect_at(base + 11, "door_f3",       8'h08, 0, 0, 3'd3, 1, 0, 0, 1);
    run(2);
    close_l = 1'b1;
    drive();
    run(9);

    // open button at dwell cycle 6 extends the door by a full dwell
    base = cyc;
    expect_at(base + 6,  "open_ext_ack",   8'h00, 1, 0, 3'd3, 1, 0, 0, 1);
    expect_at(base + 7,  "open_ext_once",  8'h00, 0, 0, 3'd3, 1, 0, 0, 1);
    expect_at(base + 9,  "door_extended",  8'h00, 0, 0, 3'd3, 1, 0, 0, 1);
    expect_at(base + 13, "door_ext_last",  8'h00, 0, 0, 3'd3, 1, 0, 0, 1);
    expect_at(base + 14, "door_ext_close", 8'h00, 0, 0, 3'd3, 1, 0, 0, 0);
    run(5);
    open_l = 1'b1;
    drive();
    run(9);

    // open from IDLE, then open+close together, then close alone
    base = cyc;
    open_l = 1'b1;
    drive();
    expect_at(base + 1, "idle_open",        8'h00, 1, 0, 3'd3, 1, 0, 0, 1);
    expect_at(base + 4, "open_beats_close", 8'h00, 1, 0, 3'd3, 1, 0, 0, 1);
    expect_at(base + 5, "close_exit",       8'h00, 0, 1, 3'd3, 1, 0, 0, 0);
    expect_at(base + 6, "close_once",       8'h00, 0, 0, 3'd3, 1, 0, 0, 0);
    run(3);
    open_l  = 1'b1;
    close_l = 1'b1;
    drive();
    run(3);

    // SCAN from floor 3 going up with calls at 7 and 0
    base = cyc;
    req_l = req_l | 8'h81;
    drive();
    expect_at(base + 1,  "scan_up_start", 8'h00, 0, 0, 3'd3, 1, 1, 0, 0);
    expect_at(base + 5,  "scan_arr_f4",   8'h00, 0, 0, 3'd4, 1, 0, 0, 0);
    expect_at(base + 21, "scan_serve_f7", 8'h80, 0, 0, 3'd7, 1, 0, 0, 1);
    expect_at(base + 22, "scan_f7_once",  8'h00, 0, 0, 3'd7, 1, 0, 0, 1);
    expect_at(base + 29, "scan_idle_f7",  8'h00, 0, 0, 3'd7, 1, 0, 0, 0);
    expect_at(base + 30, "scan_reverse",  8'h00, 0, 0, 3'd7, 0, 0, 1, 0);
    expect_at(base + 34, "scan_arr_f6",   8'h00, 0, 0, 3'd6, 0, 0, 0, 0);
    expect_at(base + 35, "scan_pass_f6",  8'h00, 0, 0, 3'd6, 0, 0, 1, 0);
    expect_at(base + 65, "scan_serve_f0", 8'h01, 0, 0, 3'd0, 0, 0, 0, 1);
    run(65);
    run(8);

    // reset while moving at floor 2
    base = cyc;
    req_l = req_l | 8'h10;
    drive();
    expect_at(base + 1,  "up_again",       8'h00, 0, 0, 3'd0, 1, 1, 0, 0);
    expect_at(base + 11, "mv_f2",          8'h00, 0, 0, 3'd2, 1, 1, 0, 0);
    expect_at(base + 13, "reset_mid_move", 8'h00, 0, 0, 3'd0, 1, 0, 0, 0);
    expect_at(base + 14, "post_reset_idle",8'h00, 0, 0, 3'd0, 1, 0, 0, 0);
    run(12);
    reset   = 1'b1;
    close_l = 1'b1;
    drive();
    run(1);
    reset   = 1'b0;
    req_l   = 8'h00;
    close_l = 1'b0;
    drive();
    run(1);

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending entries want 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
